// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes on both sides and an iterative shift-add multiplier.
// One operation is in flight at a time; results hold in DONE until the consumer accepts them.
module alu_seq #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [3:0]   sel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic [W-1:0] c_hi,
    output logic         carry,
    output logic         ovf,
    output logic         zero,
    output logic         err,
    output logic         busy
);

    localparam int unsigned SH = $clog2(W);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    state_e           state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplier_q, mplier_d;
    logic [SH-1:0]    cnt_q, cnt_d;
    logic [W-1:0]     c_q, c_d;
    logic [W-1:0]     c_hi_q, c_hi_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;

    logic [W:0]       sum;
    logic [W-1:0]     diff;
    logic [SH-1:0]    shamt;
    logic [W-1:0]     alu_c;
    logic             alu_carry;
    logic             alu_ovf;
    logic             alu_err;
    logic [2*W-1:0]   acc_next;

    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = a - b;
    assign shamt = b[SH-1:0];

    // Single-cycle opcodes; MUL is handled by the FSM.
    always_comb begin
        alu_c     = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (sel)
            4'd0: begin
                alu_c     = sum[W-1:0];
                alu_carry = sum[W];
                alu_ovf   = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            4'd1: alu_c = a & b;
            4'd2: alu_c = a | b;
            4'd3: alu_c = a ^ b;
            4'd4: begin
                alu_c     = diff;
                alu_carry = (a < b);
                alu_ovf   = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
            end
            4'd5: alu_c = a << shamt;
            4'd6: alu_c = a >> shamt;
            4'd7: alu_c = '0;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        c_hi_d   = c_hi_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        err_d    = err_q;
        acc_next = acc_q + (mplier_q[cnt_q] ? (mcand_q << cnt_q) : '0);
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (sel == 4'd7) begin
                        acc_d    = '0;
                        mcand_d  = {{W{1'b0}}, a};
                        mplier_d = b;
                        cnt_d    = '0;
                        state_d  = StMul;
                    end else begin
                        c_d     = alu_c;
                        c_hi_d  = '0;
                        carry_d = alu_carry;
                        ovf_d   = alu_ovf;
                        zero_d  = (alu_c == '0);
                        err_d   = alu_err;
                        state_d = StDone;
                    end
                end
            end
            StMul: begin
                acc_d = acc_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SH'(W - 1)) begin
                    c_d     = acc_next[W-1:0];
                    c_hi_d  = acc_next[2*W-1:W];
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = (acc_next == '0);
                    err_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            c_q      <= '0;
            c_hi_q   <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            c_hi_q   <= c_hi_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StMul);
    assign c         = c_q;
    assign c_hi      = c_hi_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (W=4): hand-computed vectors, one task per scenario.
// Observed word is {out_valid, c_hi, c, carry, ovf, zero, err, busy}.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] c;
    logic [3:0] c_hi;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_seq #(.W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .c_hi      (c_hi),
        .carry     (carry),
        .ovf       (ovf),
        .zero      (zero),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] obs();
        return {out_valid, c_hi, c, carry, ovf, zero, err, busy};
    endfunction

    // Presents an op on a falling edge, lets the next rising edge accept it,
    // and returns on the following falling edge with in_valid dropped.
    task automatic start_op(input logic [3:0] s, input logic [3:0] av, input logic [3:0] bv);
        @(negedge clk);
        sel = s; a = av; b = bv; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (obs() !== 14'h0) begin
            errors++; $display("FAIL reset_outputs got %h exp %h", obs(), 14'h0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        start_op(4'd0, 4'd8, 4'd6);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd14, 5'b00000}) begin
            errors++; $display("FAIL add_8_6 got %h exp %h", obs(), {1'b1, 4'd0, 4'd14, 5'b00000});
        end
        consume();
        start_op(4'd0, 4'd10, 4'd8);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd2, 5'b11000}) begin
            errors++; $display("FAIL add_10_8 got %h exp %h", obs(), {1'b1, 4'd0, 4'd2, 5'b11000});
        end
        consume();
    endtask

    task automatic test_logic_sub();
        start_op(4'd1, 4'd8, 4'd6);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd0, 5'b00100}) begin
            errors++; $display("FAIL and_8_6 got %h exp %h", obs(), {1'b1, 4'd0, 4'd0, 5'b00100});
        end
        consume();
        start_op(4'd4, 4'd3, 4'd5);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd14, 5'b10000}) begin
            errors++; $display("FAIL sub_3_5 got %h exp %h", obs(), {1'b1, 4'd0, 4'd14, 5'b10000});
        end
        consume();
        start_op(4'd3, 4'd1, 4'd1);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd0, 5'b00100}) begin
            errors++; $display("FAIL xor_1_1 got %h exp %h", obs(), {1'b1, 4'd0, 4'd0, 5'b00100});
        end
        consume();
        start_op(4'd2, 4'd9, 4'd4);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd13, 5'b00000}) begin
            errors++; $display("FAIL or_9_4 got %h exp %h", obs(), {1'b1, 4'd0, 4'd13, 5'b00000});
        end
        consume();
    endtask

    task automatic test_mul();
        int n;
        int busy_cnt;
        start_op(4'd7, 4'd10, 4'd2);
        n = 1;
        busy_cnt = 0;
        while (!out_valid && n < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 5) begin
            errors++; $display("FAIL mul_latency got %0d exp 5", n);
        end
        checks++;
        if (busy_cnt != 4) begin
            errors++; $display("FAIL mul_busy_cycles got %0d exp 4", busy_cnt);
        end
        checks++;
        if (obs() !== {1'b1, 4'd1, 4'd4, 5'b00000}) begin
            errors++; $display("FAIL mul_10_2 got %h exp %h", obs(), {1'b1, 4'd1, 4'd4, 5'b00000});
        end
        consume();
        start_op(4'd7, 4'd15, 4'd15);
        n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (obs() !== {1'b1, 4'd14, 4'd1, 5'b00000}) begin
            errors++; $display("FAIL mul_15_15 got %h exp %h", obs(), {1'b1, 4'd14, 4'd1, 5'b00000});
        end
        consume();
    endtask

    task automatic test_backpressure();
        start_op(4'd0, 4'd1, 4'd5);
        // A competing op offered while DONE must not be taken.
        sel = 4'd1; a = 4'd15; b = 4'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({obs(), in_ready} !== {1'b1, 4'd0, 4'd6, 5'b00000, 1'b0}) begin
                errors++;
                $display("FAIL hold_cycle%0d got %h exp %h", i, {obs(), in_ready},
                         {1'b1, 4'd0, 4'd6, 5'b00000, 1'b0});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        consume();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++; $display("FAIL release got rdy/vld %b exp 10", {in_ready, out_valid});
        end
    endtask

    task automatic test_reset_mid_mul();
        start_op(4'd7, 4'd15, 4'd15);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({obs(), in_ready} !== {14'h0, 1'b1}) begin
            errors++; $display("FAIL mid_mul_reset got %h exp %h", {obs(), in_ready}, {14'h0, 1'b1});
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(4'd0, 4'd3, 4'd2);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd5, 5'b00000}) begin
            errors++; $display("FAIL add_after_reset got %h exp %h", obs(), {1'b1, 4'd0, 4'd5, 5'b00000});
        end
        consume();
    endtask

    task automatic test_err_shift();
        start_op(4'd9, 4'd10, 4'd2);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd0, 5'b00110}) begin
            errors++; $display("FAIL illegal_op got %h exp %h", obs(), {1'b1, 4'd0, 4'd0, 5'b00110});
        end
        consume();
        start_op(4'd5, 4'd3, 4'd2);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd12, 5'b00000}) begin
            errors++; $display("FAIL shl_3_2 got %h exp %h", obs(), {1'b1, 4'd0, 4'd12, 5'b00000});
        end
        consume();
        start_op(4'd6, 4'd10, 4'd5);
        checks++;
        if (obs() !== {1'b1, 4'd0, 4'd5, 5'b00000}) begin
            errors++; $display("FAIL shr_10_5 got %h exp %h", obs(), {1'b1, 4'd0, 4'd5, 5'b00000});
        end
        consume();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sel = '0;
        test_reset();
        test_add();
        test_logic_sub();
        test_mul();
        test_backpressure();
        test_reset_mid_mul();
        test_err_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
